mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-stage data-access sequencer sitting directly downstream of the load/store address generator.
- Accepts a computed effective address, the aluSelect op code, store data and destination register.
- Drives a word-aligned data-memory request/acknowledge handshake, builds byte strobes, and aligns and extends load data.
- Holds the pipeline (stall) while the access is outstanding; returns a one-cycle response to writeback.

Parameters:
TIMEOUT_CYCLES, 16, cycles waiting for mem_ack before aborting with error; 0 = never time out
TIMEOUT_W, 8, width of internal wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present from address stage
req_ready  output  1  unit can accept a request this cycle
aluSelect  input  6  op: 0x0B LB, 0x0C LH, 0x0D LW, 0x0E LBU, 0x0F LHU, 0x10 SB, 0x11 SH, 0x12 SW
address  input  32  effective byte address
store_data  input  32  rs2 value for stores
rd_in  input  5  destination register tag
stall  output  1  high while an access is outstanding
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  32  {address[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte-lane write enables (0 for loads)
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  memory completes access this cycle
resp_valid  output  1  one-cycle completion pulse
resp_is_load  output  1  response belongs to a load
resp_err  output  1  access aborted (timeout or misalign)
load_data  output  32  aligned, extended load result (0 for stores/errors)
rd_out  output  5  registered rd_in

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 except req_ready=1; wait counter 0. Reset mid-access drops mem_req at once; no response is issued.
- FSM: IDLE, ACCESS, RESP.
- IDLE: req_ready=1, stall=0. On req_valid with op in 0x0B..0x12, register op, address, store_data and rd_in, then go to ACCESS.
  - req_valid with any other op is ignored; the unit stays in IDLE and issues no response.
- ACCESS: req_ready=0, stall=1, mem_req=1, address/data/strobes stable.
  - If mem_ack is sampled high, capture mem_rdata and go to RESP.
  - Otherwise increment the counter. When counter+1 equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), go to RESP with resp_err=1.
- RESP: resp_valid=1 for exactly one cycle; stall=1, req_ready=0. Then go to IDLE and clear the counter. Response outputs return to 0 in IDLE.
- Latency: accept at edge N; mem_req high in cycle N+1; zero-wait ack gives resp_valid in cycle N+2. Each wait state adds 1 cycle.
- Store lanes (a = address[1:0]):
  - SB: wstrb = 1<<a; wdata = byte replicated ×4.
  - SH: wstrb = a[1] ? 1100 : 0011; wdata = half replicated ×2.
  - SW: wstrb = 1111.
- Load extraction: byte at lane a; half at lane a[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Misalignment without the feature: SH/LH/LHU ignore a[0]; SW/LW ignore a[1:0].
- Store response: resp_is_load=0, load_data=0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: halfword ops with a[0]=1 and word ops with a≠0 never assert mem_req. They go IDLE→RESP directly, with resp_err=1 and load_data=0.
- Undefined: behaviour per the misalignment rules above; resp_err is asserted only on timeout.

Test Plan:
- Reset mid-ACCESS: assert reset while mem_req=1 → mem_req=0 the same cycle, state IDLE, req_ready=1, no resp_valid.
- SB to 0x1003, store_data=0xAABBCCDD, ack next cycle → mem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, resp_valid pulse at N+2, resp_is_load=0.
- LB from 0x2002 with mem_rdata=0x12F45678 → load_data=0xFFFFFFF4. Same access as LBU → 0x000000F4. LHU at 0x2002 → 0x000012F4.
- LW with mem_ack delayed 5 cycles → stall high for 7 cycles, load_data=mem_rdata, rd_out=rd_in.
- TIMEOUT_CYCLES=4, ack never asserted → mem_req high for 4 cycles, then resp_valid=1 with resp_err=1 and load_data=0.
- With MISALIGN_TRAP_EN, SW to 0x3001 → no mem_req, resp_err=1 at N+1. Without it → mem_addr=0x3000, wstrb=1111.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles the request, data-memory and writeback-response signals of the
//   memory-stage access sequencer.
//   modport master : the access unit (accepts requests, drives the memory bus
//                    and the response)
//   modport slave  : the surrounding pipeline/memory (drives requests and the
//                    memory acknowledge, consumes the response)
interface mem_access_unit_if;
    // request from the address stage
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  aluSelect;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        stall;
    // data-memory handshake
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // writeback response
    logic        resp_valid;
    logic        resp_is_load;
    logic        resp_err;
    logic [31:0] load_data;
    logic [4:0]  rd_out;

    modport master (
        input  req_valid, aluSelect, address, store_data, rd_in,
               mem_rdata, mem_ack,
        output req_ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
               mem_wstrb, resp_valid, resp_is_load, resp_err, load_data, rd_out
    );

    modport slave (
        output req_valid, aluSelect, address, store_data, rd_in,
               mem_rdata, mem_ack,
        input  req_ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
               mem_wstrb, resp_valid, resp_is_load, resp_err, load_data, rd_out
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage data-access sequencer. Takes an effective address, op code,
//   store data and destination tag; runs one word-aligned request/acknowledge
//   access on the data-memory bus (byte strobes, lane-replicated write data);
//   aligns and sign/zero-extends load data; holds stall while busy and issues
//   a one-cycle response to writeback.
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high reset
//     bus   - mem_access_unit_if.master (request, memory bus, response)
//   Parameters:
//     TIMEOUT_CYCLES - cycles to wait for mem_ack before aborting (0 = never)
//     TIMEOUT_W      - width of the wait counter
//   Optional build macro:
//     MISALIGN_TRAP_EN - misaligned half/word accesses skip the memory bus and
//                        respond immediately with resp_err=1
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input logic               clk,
    input logic               reset,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [5:0] OP_LB  = 6'h0B;
    localparam logic [5:0] OP_LH  = 6'h0C;
    localparam logic [5:0] OP_LW  = 6'h0D;
    localparam logic [5:0] OP_LBU = 6'h0E;
    localparam logic [5:0] OP_LHU = 6'h0F;
    localparam logic [5:0] OP_SB  = 6'h10;
    localparam logic [5:0] OP_SH  = 6'h11;
    localparam logic [5:0] OP_SW  = 6'h12;

    state_t               state;
    logic [TIMEOUT_W-1:0] cnt;
    logic [5:0]           op_q;
    logic [1:0]           off_q;

    logic        op_valid;
    logic        op_is_load;
    logic        q_is_load;
    logic        misalign;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] rdata_x;
    logic        timeout_hit;

    // Request decode: validity, strobes and replicated write data.
    always_comb begin
        op_valid   = (bus.aluSelect >= OP_LB) && (bus.aluSelect <= OP_SW);
        op_is_load = (bus.aluSelect <= OP_LHU);
        wstrb_n    = '0;
        wdata_n    = '0;
        misalign   = 1'b0;
        case (bus.aluSelect)
            OP_SB: begin
                wstrb_n = 4'b0001 << bus.address[1:0];
                wdata_n = {4{bus.store_data[7:0]}};
            end
            OP_SH: begin
                wstrb_n = bus.address[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{bus.store_data[15:0]}};
            end
            OP_SW: begin
                wstrb_n = 4'b1111;
                wdata_n = bus.store_data;
            end
            default: ;
        endcase
`ifdef MISALIGN_TRAP_EN
        case (bus.aluSelect)
            OP_LH, OP_LHU, OP_SH: misalign = bus.address[0];
            OP_LW, OP_SW:         misalign = |bus.address[1:0];
            default:              misalign = 1'b0;
        endcase
`endif
    end

    // Load alignment from the registered op/offset; stores yield 0.
    always_comb begin
        q_is_load = (op_q <= OP_LHU);
        byte_v    = 8'(bus.mem_rdata >> {off_q, 3'b000});
        half_v    = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (op_q)
            OP_LB:   rdata_x = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  rdata_x = {24'd0, byte_v};
            OP_LH:   rdata_x = {{16{half_v[15]}}, half_v};
            OP_LHU:  rdata_x = {16'd0, half_v};
            OP_LW:   rdata_x = bus.mem_rdata;
            default: rdata_x = '0;
        endcase
        timeout_hit = (TIMEOUT_CYCLES != 0) &&
                      ((32'(cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            op_q             <= '0;
            off_q            <= '0;
            bus.req_ready    <= 1'b1;
            bus.stall        <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_wstrb    <= '0;
            bus.resp_valid   <= 1'b0;
            bus.resp_is_load <= 1'b0;
            bus.resp_err     <= 1'b0;
            bus.load_data    <= '0;
            bus.rd_out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && op_valid) begin
                        op_q          <= bus.aluSelect;
                        off_q         <= bus.address[1:0];
                        bus.rd_out    <= bus.rd_in;
                        bus.req_ready <= 1'b0;
                        bus.stall     <= 1'b1;
                        if (misalign) begin
                            // Trapped access: straight to the response, bus untouched.
                            state            <= RESP;
                            bus.resp_valid   <= 1'b1;
                            bus.resp_err     <= 1'b1;
                            bus.resp_is_load <= op_is_load;
                            bus.load_data    <= '0;
                        end else begin
                            state         <= ACCESS;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= ~op_is_load;
                            bus.mem_addr  <= {bus.address[31:2], 2'b00};
                            bus.mem_wdata <= wdata_n;
                            bus.mem_wstrb <= wstrb_n;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack || timeout_hit) begin
                        state            <= RESP;
                        bus.mem_req      <= 1'b0;
                        bus.mem_we       <= 1'b0;
                        bus.mem_addr     <= '0;
                        bus.mem_wdata    <= '0;
                        bus.mem_wstrb    <= '0;
                        bus.resp_valid   <= 1'b1;
                        bus.resp_is_load <= q_is_load;
                        // An ack in the timeout cycle still completes normally.
                        bus.resp_err     <= ~bus.mem_ack;
                        bus.load_data    <= bus.mem_ack ? rdata_x : '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state            <= IDLE;
                    cnt              <= '0;
                    bus.req_ready    <= 1'b1;
                    bus.stall        <= 1'b0;
                    bus.resp_valid   <= 1'b0;
                    bus.resp_is_load <= 1'b0;
                    bus.resp_err     <= 1'b0;
                    bus.load_data    <= '0;
                    bus.rd_out       <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
